// File: rtl/hash_serial_host.sv
// Host-side sequencer for a bit-serial hashing core: shifts a message out MSB first,
// pulses start, waits for ready, then collects the digest LSB first.
// Optional WAIT-state watchdog is built only with `define HASH_HOST_TIMEOUT_EN.
module hash_serial_host #(
  parameter int Y              = 64,
  parameter int L              = 256,
  parameter int START_CYCLES   = 2,
  parameter int READ_GAP       = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [Y-1:0] msg_in,
  output logic         messagexSO,
  output logic         startxSO,
  input  logic         hash_digestxSI,
  input  logic         hash_readyxSI,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [L-1:0] digest_out,
  output logic         rsp_error,
  output logic         busy
);
  localparam int MAX_YL  = (Y > L) ? Y : L;
  localparam int MAX_SG  = (START_CYCLES > READ_GAP) ? START_CYCLES : READ_GAP;
  localparam int MAX_ALL = (MAX_YL > MAX_SG) ? MAX_YL : MAX_SG;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] SHIFT_LAST = CW'(Y - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((READ_GAP > 0) ? READ_GAP - 1 : 0);
  localparam logic [CW-1:0] READ_LAST  = CW'(L - 1);

  if (Y < 1 || L < 1 || START_CYCLES < 1 || READ_GAP < 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("hash_serial_host: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, SHIFT, START, WAIT, GAP, READ, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [Y-1:0]  msg_q, msg_d;
  logic [L-1:0]  digest_q, digest_d;

`ifdef HASH_HOST_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
  logic           wd_expired;

  assign wd_expired = (wd_q == WD_LAST);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      msg_q    <= '0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      msg_q    <= msg_d;
      digest_q <= digest_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (req_valid) state_d = SHIFT;
      SHIFT: if (cnt_q == SHIFT_LAST) state_d = START;
      START: if (cnt_q == START_LAST) state_d = WAIT;
      WAIT: begin
        if (hash_readyxSI) state_d = (READ_GAP == 0) ? READ : GAP;
`ifdef HASH_HOST_TIMEOUT_EN
        else if (wd_expired) state_d = DONE;
`endif
      end
      GAP:   if (cnt_q == GAP_LAST) state_d = READ;
      READ:  if (cnt_q == READ_LAST) state_d = DONE;
      DONE:  if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter restarts on every state change; message shifts left, digest fills from the top.
  always_comb begin
    cnt_d    = cnt_q;
    msg_d    = msg_q;
    digest_d = digest_q;
    if (state_d != state_q) cnt_d = '0;
    else if (state_q inside {SHIFT, START, GAP, READ}) cnt_d = cnt_q + CW'(1);
    case (state_q)
      IDLE: if (req_valid) begin
        msg_d    = msg_in;
        digest_d = '0;
      end
      SHIFT: msg_d = msg_q << 1;
      READ:  digest_d = (digest_q >> 1) | (L'(hash_digestxSI) << (L - 1));
      default: ;
    endcase
  end

`ifdef HASH_HOST_TIMEOUT_EN
  always_comb begin
    wd_d  = (state_q == WAIT && state_d == WAIT) ? wd_q + WDW'(1) : '0;
    err_d = err_q;
    if (state_q == IDLE && req_valid) err_d = 1'b0;
    else if (state_q == WAIT && !hash_readyxSI && wd_expired) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign rsp_error = err_q;
`else
  assign rsp_error = 1'b0;
`endif

  always_comb begin
    req_ready  = (state_q == IDLE);
    busy       = (state_q != IDLE);
    messagexSO = (state_q == SHIFT) && msg_q[Y-1];
    startxSO   = (state_q == START);
    rsp_valid  = (state_q == DONE);
    digest_out = digest_q;
  end

endmodule
